// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the two-requester APB arbiter.
// Used by apb_arbiter_if, apb_rr_arbiter and apb_arbiter.
package apb_arb_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 2;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

endpackage

// File: rtl/apb_arbiter_if.sv
// Bus bundle: requester-side APB lanes plus the shared slave port.
// The arbiter uses the slave modport; the environment uses master.
interface apb_arbiter_if
  import apb_arb_pkg::*;
();

  logic [NUM_REQ-1:0]        m_psel;
  logic [NUM_REQ-1:0]        m_penable;
  logic [NUM_REQ*ADDR_W-1:0] m_paddr;
  logic [NUM_REQ-1:0]        m_pwrite;
  logic [NUM_REQ*DATA_W-1:0] m_pwdata;
  logic [NUM_REQ*DATA_W-1:0] m_prdata;
  logic [NUM_REQ-1:0]        m_pready;

  logic              s_psel;
  logic              s_penable;
  logic              s_pwrite;
  logic [ADDR_W-1:0] s_paddr;
  logic [DATA_W-1:0] s_pwdata;
  logic [DATA_W-1:0] s_prdata;
  logic              s_pready;

  logic arb_timeout;

  modport slave (
    input  m_psel, m_penable, m_paddr,
    input  m_pwrite, m_pwdata,
    output m_prdata, m_pready,
    output s_psel, s_penable, s_pwrite,
    output s_paddr, s_pwdata,
    input  s_prdata, s_pready,
    output arb_timeout
  );

  modport master (
    output m_psel, m_penable, m_paddr,
    output m_pwrite, m_pwdata,
    input  m_prdata, m_pready,
    input  s_psel, s_penable, s_pwrite,
    input  s_paddr, s_pwdata,
    output s_prdata, s_pready,
    input  arb_timeout
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: the requester not served last wins a tie.
// last is the index of the previously granted requester.
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] gnt
);

  // Mutually exclusive one-hot grant selection
  always_comb begin
    gnt = '0;
    unique case (1'b1)
      req[0] && (!req[1] || last):  gnt = 2'b01;
      req[1] && (!req[0] || !last): gnt = 2'b10;
      default:                      gnt = '0;
    endcase
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter with a single outstanding slave transfer.
// Optional ACCESS wait timeout enabled by APB_ARB_TIMEOUT_EN.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic        PCLK,
  input logic        PRESET,
  apb_arbiter_if.slave bus
);

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] gnt;
  logic               last;
  logic               sel;
  logic               psel;
  logic               pen;
  logic               pwr;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;
  logic [DATA_W-1:0]  rdata;
  logic               tmo;
  logic               fin;
  logic               unused_ok;

  apb_rr_arbiter u_rr (
    .req  (bus.m_psel),
    .last (last),
    .gnt  (gnt)
  );

  assign sel = gnt[1];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign tmo = (state == ACCESS) && !bus.s_pready
            && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count unanswered ACCESS cycles; restart on each new transfer
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
    end else if (state == IDLE && |bus.m_psel) begin
      cnt <= '0;
    end else if (state == ACCESS && !bus.s_pready && !tmo) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign fin   = (state == ACCESS) && (bus.s_pready || tmo);
  assign rdata = tmo ? TIMEOUT_RDATA : bus.s_prdata;

  // Penable never affects arbitration
  assign unused_ok = ^{bus.m_penable, TIMEOUT_CYCLES[0]};

  // Transfer FSM; slave controls and captured request are registered
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state  <= IDLE;
      grant  <= '0;
      last   <= 1'b1;
      psel   <= 1'b0;
      pen    <= 1'b0;
      pwr    <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.m_psel) begin
            state  <= SETUP;
            grant  <= gnt;
            psel   <= 1'b1;
            pen    <= 1'b0;
            pwr    <= bus.m_pwrite[sel];
            paddr  <= bus.m_paddr[int'(sel)*ADDR_W +: ADDR_W];
            pwdata <= bus.m_pwdata[int'(sel)*DATA_W +: DATA_W];
          end
        end
        SETUP: begin
          state <= ACCESS;
          pen   <= 1'b1;
        end
        ACCESS: begin
          if (fin) begin
            state  <= IDLE;
            last   <= grant[1];
            grant  <= '0;
            psel   <= 1'b0;
            pen    <= 1'b0;
            pwr    <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is routed only to a granted requester still selecting
  always_comb begin
    bus.m_pready = '0;
    bus.m_prdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fin && grant[i] && bus.m_psel[i]) begin
        bus.m_pready[i] = 1'b1;
        bus.m_prdata[i*DATA_W +: DATA_W] = rdata;
      end
    end
  end

  assign bus.s_psel      = psel;
  assign bus.s_penable   = pen;
  assign bus.s_pwrite    = pwr;
  assign bus.s_paddr     = paddr;
  assign bus.s_pwdata    = pwdata;
  assign bus.arb_timeout = tmo;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: latency, round-robin, waits,
// reset abort, dropped request, capture hold and optional timeout.
module tb_apb_arbiter;

  logic PCLK;
  logic PRESET;

  int n_chk;
  int n_pass;

  apb_arbiter_if bus ();

  apb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [15:0] lane(input logic [1:0] g,
                                       input logic [7:0] v);
    return g[0] ? {8'h00, v} : {v, 8'h00};
  endfunction

  // Full zero-wait transfer for a single requester
  task automatic xfer(input logic [1:0] req);
    bus.m_psel   = req;
    bus.s_pready = 1'b1;
    bus.s_prdata = 8'h3C;
    step();
    chk("x_setup", 32'(bus.s_psel), 32'd1);
    step();
    chk("x_rdy", 32'(bus.m_pready), 32'(req));
    bus.m_psel = 2'b00;
    step();
    chk("x_idle", 32'(bus.s_psel), 32'd0);
  endtask

  initial begin
    logic [1:0] eg;
    n_chk = 0;
    n_pass = 0;
    PRESET = 1'b1;
    bus.m_psel = '0;
    bus.m_penable = '0;
    bus.m_paddr = '0;
    bus.m_pwrite = '0;
    bus.m_pwdata = '0;
    bus.s_prdata = '0;
    bus.s_pready = 1'b0;
    step();
    step();
    PRESET = 1'b0;
    chk("rst_psel", 32'(bus.s_psel), 32'd0);
    chk("rst_pen", 32'(bus.s_penable), 32'd0);
    chk("rst_rdy", 32'(bus.m_pready), 32'd0);
    chk("rst_addr", 32'(bus.s_paddr), 32'd0);
    chk("rst_tmo", 32'(bus.arb_timeout), 32'd0);

    // Single write from requester 0, minimum latency
    bus.m_psel = 2'b01;
    bus.m_penable = 2'b01;
    bus.m_paddr = {5'h00, 5'h03};
    bus.m_pwdata = {8'h00, 8'hA5};
    bus.m_pwrite = 2'b01;
    bus.s_pready = 1'b1;
    chk("a_c0_psel", 32'(bus.s_psel), 32'd0);
    step();
    chk("a_c1_psel", 32'(bus.s_psel), 32'd1);
    chk("a_c1_pen", 32'(bus.s_penable), 32'd0);
    chk("a_c1_addr", 32'(bus.s_paddr), 32'h03);
    chk("a_c1_wdat", 32'(bus.s_pwdata), 32'hA5);
    chk("a_c1_wr", 32'(bus.s_pwrite), 32'd1);
    chk("a_c1_rdy", 32'(bus.m_pready), 32'd0);
    step();
    chk("a_c2_pen", 32'(bus.s_penable), 32'd1);
    chk("a_c2_rdy", 32'(bus.m_pready), 32'b01);
    bus.m_psel = 2'b00;
    bus.m_penable = 2'b00;
    step();
    chk("a_idle_sel", 32'(bus.s_psel), 32'd0);
    chk("a_idle_adr", 32'(bus.s_paddr), 32'd0);

    // Both requesters held after reset: 0,1,0,1
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    bus.m_psel = 2'b11;
    bus.m_paddr = {5'h15, 5'h0A};
    bus.m_pwrite = 2'b00;
    bus.s_pready = 1'b1;
    bus.s_prdata = 8'h77;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      chk("b_addr", 32'(bus.s_paddr),
          eg[0] ? 32'h0A : 32'h15);
      chk("b_mid_rdy", 32'(bus.m_pready), 32'd0);
      step();
      chk("b_rdy", 32'(bus.m_pready), 32'(eg));
      chk("b_rdat", 32'(bus.m_prdata),
          32'(lane(eg, 8'h77)));
      step();
      chk("b_gap", 32'(bus.s_psel), 32'd0);
    end
    bus.m_psel = 2'b00;

    // Requester 1 read with three wait states
    bus.m_psel = 2'b10;
    bus.m_paddr = {5'h1F, 5'h00};
    bus.s_pready = 1'b0;
    bus.s_prdata = 8'h5C;
    step();
    chk("c_c1_wr", 32'(bus.s_pwrite), 32'd0);
    step();
    bus.m_paddr = {5'h02, 5'h00};
    for (int k = 2; k < 5; k++) begin
      chk("c_wait_rdy", 32'(bus.m_pready), 32'd0);
      chk("c_hold_adr", 32'(bus.s_paddr), 32'h1F);
      step();
    end
    bus.s_pready = 1'b1;
    #1;
    chk("c_c5_rdy", 32'(bus.m_pready), 32'b10);
    chk("c_c5_rdat", 32'(bus.m_prdata), 32'h5C00);
    bus.m_psel = 2'b00;
    step();

    // Reset during ACCESS after a requester-0 grant
    xfer(2'b01);
    bus.m_psel = 2'b01;
    bus.m_paddr = {5'h11, 5'h07};
    bus.s_pready = 1'b0;
    step();
    step();
    chk("d_access", 32'(bus.s_penable), 32'd1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("d_psel", 32'(bus.s_psel), 32'd0);
    chk("d_pen", 32'(bus.s_penable), 32'd0);
    bus.s_pready = 1'b1;
    #1;
    chk("d_rdy", 32'(bus.m_pready), 32'd0);
    #1;
    PRESET = 1'b0;
    bus.m_psel = 2'b11;
    step();
    chk("d_regrant", 32'(bus.s_paddr), 32'h07);
    step();
    chk("d_rdy0", 32'(bus.m_pready), 32'b01);
    bus.m_psel = 2'b00;
    step();

    // Requester 1 drops select mid-transfer
    bus.m_psel = 2'b10;
    bus.s_prdata = 8'h99;
    step();
    step();
    bus.m_psel = 2'b00;
    #1;
    chk("e_slv_done", 32'(bus.s_penable), 32'd1);
    chk("e_rdy", 32'(bus.m_pready), 32'd0);
    chk("e_rdat", 32'(bus.m_prdata), 32'd0);
    step();
    bus.m_psel = 2'b11;
    step();
    chk("e_ptr", 32'(bus.s_paddr), 32'h07);
    step();
    chk("e_rdy0", 32'(bus.m_pready), 32'b01);
    bus.m_psel = 2'b00;
    step();

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never answers: forced completion on 16th wait
    bus.m_psel = 2'b01;
    bus.s_pready = 1'b0;
    bus.s_prdata = 8'h12;
    step();
    step();
    for (int k = 1; k < 16; k++) begin
      chk("t_wait_rdy", 32'(bus.m_pready), 32'd0);
      chk("t_wait_tmo", 32'(bus.arb_timeout), 32'd0);
      step();
    end
    chk("t_rdy", 32'(bus.m_pready), 32'b01);
    chk("t_rdat", 32'(bus.m_prdata), 32'h00FF);
    chk("t_tmo", 32'(bus.arb_timeout), 32'd1);
    bus.m_psel = 2'b00;
    step();
    chk("t_tmo_end", 32'(bus.arb_timeout), 32'd0);
    chk("t_idle", 32'(bus.s_psel), 32'd0);
`else
    // Slave never answers: no forced completion
    bus.m_psel = 2'b01;
    bus.s_pready = 1'b0;
    step();
    step();
    for (int k = 0; k < 20; k++) step();
    chk("n_still", 32'(bus.s_penable), 32'd1);
    chk("n_tmo", 32'(bus.arb_timeout), 32'd0);
    chk("n_rdy", 32'(bus.m_pready), 32'd0);
    bus.s_pready = 1'b1;
    #1;
    chk("n_rdy_end", 32'(bus.m_pready), 32'b01);
    bus.m_psel = 2'b00;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the consecutive slave wait cycles before forced termination (used only with APB_ARB_TIMEOUT_EN).
REQ-002 PCLK  input  1  single clock; all state SHALL be on its rising edge.
REQ-003 PRESET  input  1  asynchronous, active-high reset.
REQ-004 m_psel  input  2  per-requester APB select; bit n = requester n.
REQ-005 m_penable  input  2  per-requester APB enable; SHALL be ignored for arbitration.
REQ-006 m_paddr  input  10  requester n address in bits [5n+4:5n].
REQ-007 m_pwrite  input  2  per-requester write strobe.
REQ-008 m_pwdata  input  16  requester n write data in bits [8n+7:8n].
REQ-009 m_prdata  output  16  requester n read data in bits [8n+7:8n].
REQ-010 m_pready  output  2  per-requester transfer-complete.
REQ-011 s_psel, s_penable, s_pwrite  output  1 each  shared slave APB controls.
REQ-012 s_paddr  output  5; s_pwdata  output  8  shared slave address and write data.
REQ-013 s_prdata  input  8; s_pready  input  1  shared slave response.
REQ-014 arb_timeout  output  1  one-cycle pulse on forced termination.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS SHALL drive the slave port; only one transfer SHALL be outstanding.
REQ-016 IDLE: if any m_psel bit is high, the arbiter SHALL grant one requester, capture its paddr/pwrite/pwdata into registers, and enter SETUP next cycle.
REQ-017 Grant SHALL be round-robin: the requester not granted last wins when both request; a sole requester always wins.
REQ-018 SETUP: s_psel=1, s_penable=0; SHALL go to ACCESS unconditionally.
REQ-019 ACCESS: s_psel=1, s_penable=1; while s_pready=0 SHALL stay in ACCESS.
REQ-020 ACCESS with s_pready=1: m_pready[g]=1 and m_prdata[g]=s_prdata combinationally in that cycle; SHALL return to IDLE, and the last-grant pointer SHALL update to g.
REQ-021 Minimum latency: request seen in IDLE at cycle 0, SETUP at 1, completion at 2; one IDLE cycle SHALL separate back-to-back transfers.
REQ-022 A non-granted requester SHALL see m_pready=0 (wait states) and m_prdata=0 for its lane.
REQ-023 s_paddr/s_pwrite/s_pwdata SHALL hold captured values from SETUP through completion, independent of later requester input changes.
REQ-024 If the granted requester drops m_psel mid-transfer, the slave transfer SHALL still complete; the result SHALL be discarded, the pointer SHALL still update.
REQ-025 In IDLE all s_* outputs SHALL be 0.

Reset
REQ-026 PRESET high SHALL immediately force IDLE, all outputs to 0, the timeout counter to 0, and the last-grant pointer to 1 (requester 0 wins first).
REQ-027 Reset asserted mid-transfer SHALL abort it with no m_pready pulse; deassertion SHALL resume from IDLE on the next PCLK edge.

Configuration
REQ-028 With APB_ARB_TIMEOUT_EN defined: a counter SHALL count ACCESS cycles with s_pready=0; on reaching TIMEOUT_CYCLES, in that same cycle m_pready[g]=1, m_prdata[g]=8'hFF, and arb_timeout=1; FSM SHALL return to IDLE.
REQ-029 The counter SHALL clear on every entry to SETUP.
REQ-030 Without APB_ARB_TIMEOUT_EN: no counter; ACCESS SHALL wait indefinitely; arb_timeout SHALL be tied 0.

Structure
REQ-031 Package apb_arb_pkg SHALL hold the state enum, ADDR_W=5, DATA_W=8, NUM_REQ=2, TIMEOUT_RDATA=8'hFF.
REQ-032 Grant selection SHALL live in sub-module apb_rr_arbiter (request vector and last-grant in, one-hot grant out).

Verification
REQ-033 Requester 0 only, write addr 5'h03 data 8'hA5, s_pready=1 -> s_psel at cycle 1, s_penable at cycle 2, m_pready[0] at cycle 2, slave sees 03/A5/write.
REQ-034 Both requesters held continuously after reset -> grants alternate 0,1,0,1; each m_pready pulse on one lane only.
REQ-035 Requester 1 read, slave holds s_pready=0 for 3 cycles, then returns 8'h5C -> m_pready[1] at cycle 5, m_prdata[1]=8'h5C, requester 0 lane stays 0.
REQ-036 PRESET pulse during ACCESS -> s_psel/s_penable 0 immediately, no m_pready; next request granted to requester 0.
REQ-037 APB_ARB_TIMEOUT_EN, s_pready stuck 0 -> after 16 ACCESS wait cycles m_pready[g]=1, m_prdata=8'hFF, arb_timeout single pulse.
REQ-038 Granted requester changes m_paddr during ACCESS -> s_paddr unchanged until completion.
